// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl - RAW/branch/memory-wait stall and flush control
// Rev 1.0
// ============================================================================
module pipeline_hazard_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ID_Src1,
    input  logic [3:0]  ID_Src2,
    input  logic        ID_Two_Src,
    input  logic [3:0]  EXE_Dest,
    input  logic [3:0]  MEM_Dest,
    input  logic        EXE_WB_EN,
    input  logic        MEM_WB_EN,
    input  logic        EXE_MEM_R_EN,
    input  logic        Fwd_EN,
    input  logic        Branch_Taken,
    input  logic        Mem_Req,
    input  logic        Mem_Ready,
    output logic        IF_Freeze,
    output logic        ID_Freeze,
    output logic        EXE_Freeze,
    output logic        MEM_Freeze,
    output logic        IF_Flush,
    output logic        ID_Flush,
    output logic        Hazard,
    output logic        Mem_Timeout,
    output logic [15:0] Stall_Count,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic        exe_hit;
    logic        mem_hit;
    logic        raw_hazard;
    logic        mem_stall;
    logic        any_freeze;

    always_comb begin
        exe_hit    = EXE_WB_EN && ((EXE_Dest == ID_Src1) ||
                                   (ID_Two_Src && (EXE_Dest == ID_Src2)));
        mem_hit    = MEM_WB_EN && ((MEM_Dest == ID_Src1) ||
                                   (ID_Two_Src && (MEM_Dest == ID_Src2)));
        // With forwarding only a load in EXE cannot be bypassed in time
        raw_hazard = Fwd_EN ? (exe_hit && EXE_MEM_R_EN) : (exe_hit || mem_hit);
        mem_stall  = Mem_Req && !Mem_Ready;
    end

    always_comb begin
        IF_Freeze  = 1'b0;
        ID_Freeze  = 1'b0;
        EXE_Freeze = 1'b0;
        MEM_Freeze = 1'b0;
        IF_Flush   = 1'b0;
        ID_Flush   = 1'b0;
        Hazard     = 1'b0;
        state_next = state;

        if (!RST) begin
            ID_Flush   = 1'b1;
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        IF_Freeze  = 1'b1;
                        ID_Freeze  = 1'b1;
                        EXE_Freeze = 1'b1;
                        MEM_Freeze = 1'b1;
                        state_next = ST_MEM_WAIT;
                    end else if (Branch_Taken) begin
                        IF_Flush   = 1'b1;
                        ID_Flush   = 1'b1;
                        state_next = ST_FLUSH;
                    end else if (raw_hazard) begin
                        IF_Freeze  = 1'b1;
                        ID_Freeze  = 1'b1;
                        ID_Flush   = 1'b1;
                        Hazard     = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    // Branch and RAW inputs are stale here; the frozen stages replay them
                    if (!Mem_Ready) begin
                        IF_Freeze  = 1'b1;
                        ID_Freeze  = 1'b1;
                        EXE_Freeze = 1'b1;
                        MEM_Freeze = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (mem_stall) begin
                        IF_Freeze  = 1'b1;
                        ID_Freeze  = 1'b1;
                        EXE_Freeze = 1'b1;
                        MEM_Freeze = 1'b1;
                        state_next = ST_MEM_WAIT;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    assign any_freeze = IF_Freeze || ID_Freeze || EXE_Freeze || MEM_Freeze;
    assign State      = state;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= ST_RUN;
            wait_cnt    <= 8'd0;
            Stall_Count <= 16'd0;
            Mem_Timeout <= 1'b0;
        end else begin
            state <= state_next;

            if ((state != ST_MEM_WAIT) && (state_next == ST_MEM_WAIT)) begin
                wait_cnt <= 8'd0;
            end else if ((state == ST_MEM_WAIT) && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            // Sticky: set on the edge where the counter lands on 255
            if ((state == ST_MEM_WAIT) && (wait_cnt == 8'hFE)) begin
                Mem_Timeout <= 1'b1;
            end

            if (any_freeze && (Stall_Count != 16'hFFFF)) begin
                Stall_Count <= Stall_Count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_ctrl - directed and randomized checks against a reference model
// Rev 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic        CLK;
    logic        RST;
    logic [3:0]  ID_Src1, ID_Src2, EXE_Dest, MEM_Dest;
    logic        ID_Two_Src, EXE_WB_EN, MEM_WB_EN, EXE_MEM_R_EN, Fwd_EN;
    logic        Branch_Taken, Mem_Req, Mem_Ready;
    logic        IF_Freeze, ID_Freeze, EXE_Freeze, MEM_Freeze;
    logic        IF_Flush, ID_Flush, Hazard, Mem_Timeout;
    logic [15:0] Stall_Count;
    logic [1:0]  State;

    pipeline_hazard_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .ID_Src1      (ID_Src1),
        .ID_Src2      (ID_Src2),
        .ID_Two_Src   (ID_Two_Src),
        .EXE_Dest     (EXE_Dest),
        .MEM_Dest     (MEM_Dest),
        .EXE_WB_EN    (EXE_WB_EN),
        .MEM_WB_EN    (MEM_WB_EN),
        .EXE_MEM_R_EN (EXE_MEM_R_EN),
        .Fwd_EN       (Fwd_EN),
        .Branch_Taken (Branch_Taken),
        .Mem_Req      (Mem_Req),
        .Mem_Ready    (Mem_Ready),
        .IF_Freeze    (IF_Freeze),
        .ID_Freeze    (ID_Freeze),
        .EXE_Freeze   (EXE_Freeze),
        .MEM_Freeze   (MEM_Freeze),
        .IF_Flush     (IF_Flush),
        .ID_Flush     (ID_Flush),
        .Hazard       (Hazard),
        .Mem_Timeout  (Mem_Timeout),
        .Stall_Count  (Stall_Count),
        .State        (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the pipeline is doing, not how the RTL encodes it
    bit m_waiting   = 1'b0;
    bit m_post_br   = 1'b0;
    int m_waited    = 0;
    bit m_timeout   = 1'b0;
    int m_stalls    = 0;
    logic [6:0] exp_ctl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // exp_ctl = {IF_Freeze, ID_Freeze, EXE_Freeze, MEM_Freeze, IF_Flush, ID_Flush, Hazard}
    task automatic model_outputs();
        bit e_hit, m_hit, raw;
        e_hit = EXE_WB_EN && (EXE_Dest == ID_Src1 || (ID_Two_Src && EXE_Dest == ID_Src2));
        m_hit = MEM_WB_EN && (MEM_Dest == ID_Src1 || (ID_Two_Src && MEM_Dest == ID_Src2));
        raw   = Fwd_EN ? (e_hit && EXE_MEM_R_EN) : (e_hit || m_hit);
        if (!RST)                        exp_ctl = 7'b0000_010;
        else if (m_waiting)              exp_ctl = Mem_Ready ? 7'b0 : 7'b1111_000;
        else if (Mem_Req && !Mem_Ready)  exp_ctl = 7'b1111_000;
        else if (m_post_br)              exp_ctl = 7'b0;
        else if (Branch_Taken)           exp_ctl = 7'b0000_110;
        else if (raw)                    exp_ctl = 7'b1100_011;
        else                             exp_ctl = 7'b0;
    endtask

    task automatic model_advance();
        if (!RST) begin
            m_waiting = 0; m_post_br = 0; m_waited = 0; m_timeout = 0; m_stalls = 0;
        end else begin
            if (exp_ctl[6:3] != 4'b0 && m_stalls < 65535) m_stalls++;
            if (m_waiting) begin
                m_waited++;
                if (m_waited >= 255) m_timeout = 1;
                if (Mem_Ready) m_waiting = 0;
            end else if (Mem_Req && !Mem_Ready) begin
                m_waiting = 1; m_waited = 0; m_post_br = 0;
            end else begin
                m_post_br = !m_post_br && Branch_Taken;
            end
        end
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic finish_cycle();
        int exp_state;
        exp_state = m_waiting ? 1 : (m_post_br ? 2 : 0);
        model_outputs();
        check("ctl", {25'b0, IF_Freeze, ID_Freeze, EXE_Freeze, MEM_Freeze, IF_Flush, ID_Flush, Hazard},
              {25'b0, exp_ctl});
        check("state", {30'b0, State}, exp_state);
        check("stall_count", {16'b0, Stall_Count}, m_stalls);
        check("timeout", {31'b0, Mem_Timeout}, {31'b0, m_timeout});
        model_advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_cycle();
        settle();
        finish_cycle();
    endtask

    task automatic idle();
        ID_Src1 = 4'd0; ID_Src2 = 4'd0; ID_Two_Src = 0; EXE_Dest = 4'd0; MEM_Dest = 4'd0;
        EXE_WB_EN = 0; MEM_WB_EN = 0; EXE_MEM_R_EN = 0; Fwd_EN = 0;
        Branch_Taken = 0; Mem_Req = 0; Mem_Ready = 1; RST = 1;
    endtask

    task automatic do_reset();
        RST = 0;
        settle();
        check("rst_id_flush", {31'b0, ID_Flush}, 32'd1);
        check("rst_freeze", {28'b0, IF_Freeze, ID_Freeze, EXE_Freeze, MEM_Freeze}, 32'd0);
        finish_cycle();
        RST = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        RST = 0;
        @(posedge CLK); #1;
        do_reset();
        run_cycle();
        check("reset_state", {30'b0, State}, 32'd0);

        // Load-use with forwarding
        Fwd_EN = 1; EXE_Dest = 4'd3; EXE_WB_EN = 1; EXE_MEM_R_EN = 1; ID_Src1 = 4'd3;
        settle();
        check("lu_hazard", {31'b0, Hazard}, 32'd1);
        check("lu_frz_flush", {29'b0, IF_Freeze, ID_Freeze, ID_Flush}, 32'd7);
        check("lu_exe_frz", {31'b0, EXE_Freeze}, 32'd0);
        finish_cycle();
        EXE_MEM_R_EN = 0;
        settle();
        check("fwd_no_hazard", {31'b0, Hazard}, 32'd0);
        finish_cycle();

        // No forwarding, MEM-stage hit on second source
        idle();
        MEM_Dest = 4'd5; MEM_WB_EN = 1; ID_Two_Src = 1; ID_Src2 = 4'd5;
        settle();
        check("nofwd_hazard", {31'b0, Hazard}, 32'd1);
        finish_cycle();
        ID_Two_Src = 0;
        settle();
        check("one_src_no_hazard", {31'b0, Hazard}, 32'd0);
        finish_cycle();

        // Four-cycle memory wait
        idle();
        do_reset();
        Mem_Req = 1; Mem_Ready = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("mw_freeze", {28'b0, IF_Freeze, ID_Freeze, EXE_Freeze, MEM_Freeze}, 32'hF);
            finish_cycle();
        end
        Mem_Ready = 1;
        settle();
        check("mw_release", {28'b0, IF_Freeze, ID_Freeze, EXE_Freeze, MEM_Freeze}, 32'd0);
        finish_cycle();
        Mem_Req = 0;
        settle();
        check("mw_state_run", {30'b0, State}, 32'd0);
        check("mw_stall_count", {16'b0, Stall_Count}, 32'd4);
        finish_cycle();

        // Branch beats RAW; memory stall beats branch
        idle();
        EXE_WB_EN = 1; EXE_Dest = 4'd2; ID_Src1 = 4'd2; Branch_Taken = 1;
        settle();
        check("br_flush", {30'b0, IF_Flush, ID_Flush}, 32'd3);
        check("br_hazard", {31'b0, Hazard}, 32'd0);
        finish_cycle();
        idle();
        settle();
        check("br_state_flush", {30'b0, State}, 32'd2);
        finish_cycle();
        EXE_WB_EN = 1; EXE_Dest = 4'd2; ID_Src1 = 4'd2; Branch_Taken = 1;
        Mem_Req = 1; Mem_Ready = 0;
        settle();
        check("ms_no_flush", {30'b0, IF_Flush, ID_Flush}, 32'd0);
        finish_cycle();
        Mem_Ready = 1;
        settle();
        check("ms_state_wait", {30'b0, State}, 32'd1);
        finish_cycle();
        idle();
        run_cycle();

        // Watchdog timeout
        do_reset();
        Mem_Req = 1; Mem_Ready = 0;
        for (int i = 0; i < 260; i++) begin
            if (i == 100) begin
                settle();
                check("tmo_early", {31'b0, Mem_Timeout}, 32'd0);
                finish_cycle();
            end else begin
                run_cycle();
            end
        end
        settle();
        check("tmo_set", {31'b0, Mem_Timeout}, 32'd1);
        finish_cycle();
        Mem_Ready = 1;
        for (int i = 0; i < 3; i++) run_cycle();
        check("tmo_sticky", {31'b0, Mem_Timeout}, 32'd1);
        idle();
        do_reset();
        settle();
        check("tmo_cleared", {31'b0, Mem_Timeout}, 32'd0);
        finish_cycle();

        // Reset aborts a memory wait
        Mem_Req = 1; Mem_Ready = 0;
        for (int i = 0; i < 3; i++) run_cycle();
        RST = 0;
        settle();
        check("rmw_freeze", {28'b0, IF_Freeze, ID_Freeze, EXE_Freeze, MEM_Freeze}, 32'd0);
        finish_cycle();
        idle();
        settle();
        check("rmw_state", {30'b0, State}, 32'd0);
        check("rmw_stalls", {16'b0, Stall_Count}, 32'd0);
        finish_cycle();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            RST          = ($urandom_range(0, 99) != 0);
            ID_Src1      = 4'($urandom_range(0, 3));
            ID_Src2      = 4'($urandom_range(0, 3));
            EXE_Dest     = 4'($urandom_range(0, 3));
            MEM_Dest     = 4'($urandom_range(0, 3));
            ID_Two_Src   = 1'($urandom);
            EXE_WB_EN    = 1'($urandom);
            MEM_WB_EN    = 1'($urandom);
            EXE_MEM_R_EN = 1'($urandom);
            Fwd_EN       = 1'($urandom);
            Branch_Taken = ($urandom_range(0, 5) == 0);
            Mem_Req      = ($urandom_range(0, 3) == 0);
            Mem_Ready    = ($urandom_range(0, 2) != 0);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: CLK and RST.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST  in  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-004 ID_Src1, ID_Src2  in  4 each  source register numbers of the instruction in ID.
REQ-005 ID_Two_Src  in  1  when 1, ID_Src2 is a real operand.
REQ-006 EXE_Dest, MEM_Dest  in  4 each  destination register numbers in the EXE and MEM stages.
REQ-007 EXE_WB_EN, MEM_WB_EN  in  1 each  write-back valid flags for the EXE and MEM stages.
REQ-008 EXE_MEM_R_EN  in  1  the EXE-stage instruction is a load.
REQ-009 Fwd_EN  in  1  forwarding enabled.
REQ-010 Branch_Taken  in  1  branch resolved as taken in EXE.
REQ-011 Mem_Req, Mem_Ready  in  1 each  data-memory access in MEM, and its completion.
REQ-012 IF_Freeze, ID_Freeze, EXE_Freeze, MEM_Freeze  out  1 each  hold (no-load) for the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 IF_Flush, ID_Flush  out  1 each  clear the IF/ID and ID/EX registers (ID_Flush drives the ID/EX register's flush input).
REQ-014 Hazard  out  1  a RAW stall is inserted this cycle.
REQ-015 Mem_Timeout  out  1  sticky watchdog error flag.
REQ-016 Stall_Count  out  16  number of freeze cycles since reset.
REQ-017 State  out  2  current FSM state: RUN=0, MEM_WAIT=1, FLUSH=2.

Function
REQ-018 Raw hit SHALL be: (WB_EN && Dest==ID_Src1) || (ID_Two_Src && WB_EN && Dest==ID_Src2), evaluated separately for EXE and for MEM.
REQ-019 Fwd_EN=0: Hazard = EXE hit || MEM hit. Fwd_EN=1: Hazard = EXE hit && EXE_MEM_R_EN (load-use only).
REQ-020 Hazard, freeze and flush outputs SHALL be combinational from State and the current inputs; State, counters and Mem_Timeout SHALL be registered.
REQ-021 Priority within one cycle SHALL be: memory stall > Branch_Taken > Hazard.
REQ-022 RUN, when Mem_Req=1 and Mem_Ready=0: all four freezes = 1, flushes = 0, Hazard = 0; next state MEM_WAIT.
REQ-023 RUN, when Branch_Taken=1 and there is no memory stall: IF_Flush = 1, ID_Flush = 1, freezes = 0, Hazard = 0; next state FLUSH.
REQ-024 RUN, when Hazard=1 and there is no memory stall or branch: IF_Freeze = 1, ID_Freeze = 1, ID_Flush = 1 (bubble), EXE_Freeze = 0, MEM_Freeze = 0; State stays RUN.
REQ-025 RUN, otherwise: all freeze and flush outputs = 0.
REQ-026 MEM_WAIT: all four freezes = 1 and flushes = 0 while Mem_Ready=0.
REQ-027 MEM_WAIT, in the cycle Mem_Ready=1: freezes drop to 0 that same cycle and the next state is RUN.
REQ-028 In MEM_WAIT, Branch_Taken and Hazard SHALL be ignored; the frozen stages re-present them after return to RUN.
REQ-029 FLUSH lasts exactly one cycle: Hazard is forced to 0 (ID holds a bubble), the memory-stall rule of REQ-022 still applies, and the next state is RUN (or MEM_WAIT on a memory stall).
REQ-030 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each cycle spent in MEM_WAIT.
REQ-031 When the wait counter reaches 255, Mem_Timeout SHALL set and stay set until reset; the FSM SHALL remain in MEM_WAIT.
REQ-032 Stall_Count SHALL increment in every cycle in which any freeze output is 1, saturating at 0xFFFF.
REQ-033 The encoding State=3 is illegal and SHALL go to RUN on the next clock.

Reset
REQ-034 With RST=0 at a clock edge: State=RUN, wait counter=0, Stall_Count=0, Mem_Timeout=0.
REQ-035 While RST=0: all freezes = 0, IF_Flush = 0, ID_Flush = 1, Hazard = 0.
REQ-036 Reset asserted mid-MEM_WAIT SHALL abort the wait; RUN is entered on the next edge.

Verification
REQ-037 Load-use: Fwd_EN=1, EXE_Dest=3, EXE_WB_EN=1, EXE_MEM_R_EN=1, ID_Src1=3 -> Hazard=1, IF_Freeze=1, ID_Freeze=1, ID_Flush=1 for one cycle; repeat with Fwd_EN=1 and EXE_MEM_R_EN=0 -> Hazard=0.
REQ-038 No forwarding: Fwd_EN=0, MEM_Dest=5, MEM_WB_EN=1, ID_Two_Src=1, ID_Src2=5 -> Hazard=1; repeat with ID_Two_Src=0 -> Hazard=0.
REQ-039 Memory wait: Mem_Req=1, Mem_Ready=0 for 4 cycles then Mem_Ready=1 -> freezes high for 4 cycles, low in the 5th, State back to RUN, Stall_Count=4.
REQ-040 Priority: Branch_Taken=1 together with a RAW hit in RUN -> IF_Flush=1, ID_Flush=1, Hazard=0, State=FLUSH next cycle; repeat with a concurrent memory stall -> MEM_WAIT, no flush.
REQ-041 Timeout: Mem_Ready held 0 for 260 cycles -> Mem_Timeout=1 from cycle 255 onward; it stays 1 after Mem_Ready=1 and clears only after RST=0.
REQ-042 Reset mid-wait: RST=0 during MEM_WAIT -> State=RUN, Stall_Count=0, freezes=0 on the next edge.
